// File: rtl/mem_ctrl.sv
// LC-3 memory / memory-mapped I/O controller: owns MAR and MDR, sequences RAM accesses, decodes the device page.
// Latency: rdy asserts after MEM_LATENCY consecutive mio_en cycles; device registers update on the rdy edge.
// Backpressure: the CPU holds mio_en until rdy; dropping mio_en aborts the access with no side effects.
module mem_ctrl #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] bus,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        gate_mdr,
    input  logic        mio_en,
    input  logic        rw,
    output logic        rdy,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    input  logic        kbd_strobe,
    input  logic [7:0]  kbd_char,
    output logic        dsp_strobe,
    output logic [7:0]  dsp_char,
    input  logic        dsp_ack,
    output logic        kbd_irq,
    output logic        dsp_irq,
    output logic        run
);

    // Counter must be at least 2 bits and wide enough to reach MEM_LATENCY-1.
    localparam int CW = (MEM_LATENCY <= 4) ? 2 : $clog2(MEM_LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    logic [15:0]   mar;
    logic [15:0]   mdr;
    logic [CW-1:0] cnt;
    logic [15:0]   rd_mux;

    logic          kbsr_rdy;
    logic          kbsr_ie;
    logic [7:0]    kbdr;
    logic          dsr_rdy;
    logic          dsr_ie;
    logic          mcr_run;

    logic          in_dev;
    logic          dev_wr;
    logic          wr_kbsr;
    logic          wr_dsr;
    logic          wr_ddr;
    logic          wr_mcr;
    logic          rd_kbdr;

    // Everything at or above xFE00 is the device page.
    assign in_dev = (mar[15:9] == 7'h7F);

    assign rdy     = mio_en && (cnt == CNT_LAST);
    assign dev_wr  = rdy && rw && in_dev;
    assign wr_kbsr = dev_wr && (mar == ADDR_KBSR);
    assign wr_dsr  = dev_wr && (mar == ADDR_DSR);
    assign wr_ddr  = dev_wr && (mar == ADDR_DDR);
    assign wr_mcr  = dev_wr && (mar == ADDR_MCR);
    assign rd_kbdr = rdy && !rw && (mar == ADDR_KBDR);

    assign ram_addr  = mar;
    assign ram_wdata = mdr;
    assign ram_we    = rdy && rw && !in_dev;

    assign kbd_irq = kbsr_rdy && kbsr_ie;
    assign dsp_irq = dsr_rdy && dsr_ie;
    assign run     = mcr_run;

    // MDR drives the shared bus only while gated; the bus follows gate_mdr combinationally.
    assign bus = gate_mdr ? mdr : 16'bz;

    // Read mux: RAM below the device page, decoded registers above, zero for unmapped device addresses.
    always_comb begin
        rd_mux = 16'h0000;
        if (!in_dev) begin
            rd_mux = ram_rdata;
        end else begin
            case (mar)
                ADDR_KBSR: rd_mux = {kbsr_rdy, kbsr_ie, 14'b0};
                ADDR_KBDR: rd_mux = {8'b0, kbdr};
                ADDR_DSR:  rd_mux = {dsr_rdy, dsr_ie, 14'b0};
                ADDR_DDR:  rd_mux = {8'b0, dsp_char};
                ADDR_MCR:  rd_mux = {mcr_run, 15'b0};
                default:   rd_mux = 16'h0000;
            endcase
        end
    end

    // Access sequencer: count consecutive mio_en cycles; clear on completion or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!mio_en || rdy) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // MAR/MDR: MDR takes the read mux during a memory cycle, otherwise the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mar <= 16'h0000;
            mdr <= 16'h0000;
        end else begin
            if (ld_mar) begin
                mar <= bus;
            end
            if (ld_mdr) begin
                mdr <= mio_en ? rd_mux : bus;
            end
        end
    end

    // Device registers; later statements take priority so the keyboard strobe beats a KBDR read
    // and a DDR write beats a simultaneous dsp_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbsr_rdy   <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= 8'h00;
            dsr_rdy    <= 1'b1;
            dsr_ie     <= 1'b0;
            mcr_run    <= 1'b1;
            dsp_char   <= 8'h00;
            dsp_strobe <= 1'b0;
        end else begin
            dsp_strobe <= wr_ddr;
            if (dsp_ack) begin
                dsr_rdy <= 1'b1;
            end
            if (wr_ddr) begin
                dsr_rdy  <= 1'b0;
                dsp_char <= mdr[7:0];
            end
            if (wr_kbsr) begin
                kbsr_ie <= mdr[14];
            end
            if (wr_dsr) begin
                dsr_ie <= mdr[14];
            end
            if (wr_mcr) begin
                mcr_run <= mdr[15];
            end
            if (rd_kbdr) begin
                kbsr_rdy <= 1'b0;
            end
            if (kbd_strobe) begin
                kbsr_rdy <= 1'b1;
                kbdr     <= kbd_char;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios followed by random CPU transactions.
// Expected responses are queued at issue time and popped by a monitor on rdy and gate_mdr cycles.
// The reference model works per transaction on plain variables and an associative RAM image.
module tb_mem_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] bus;
    logic [15:0] drv;
    logic        drv_en;
    logic        ld_mar, ld_mdr, gate_mdr, mio_en, rw;
    logic        rdy;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic        kbd_strobe;
    logic [7:0]  kbd_char;
    logic        dsp_strobe;
    logic [7:0]  dsp_char;
    logic        dsp_ack;
    logic        kbd_irq, dsp_irq, run;

    assign bus = drv_en ? drv : 16'bz;

    mem_ctrl #(.MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .gate_mdr(gate_mdr), .mio_en(mio_en), .rw(rw),
        .rdy(rdy), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .kbd_strobe(kbd_strobe), .kbd_char(kbd_char),
        .dsp_strobe(dsp_strobe), .dsp_char(dsp_char), .dsp_ack(dsp_ack),
        .kbd_irq(kbd_irq), .dsp_irq(dsp_irq), .run(run)
    );

    always #5 clk = ~clk;

    // Simple synchronous-write, combinational-read RAM.
    logic [15:0] phys [0:65535];
    always @(posedge clk) begin
        if (ram_we) phys[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = phys[ram_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_ram [logic [15:0]];
    logic [15:0] written [$];
    logic        m_kbsr_rdy, m_kbsr_ie, m_dsr_rdy, m_dsr_ie, m_run;
    logic [7:0]  m_kbdr, m_dsp_char;

    task automatic model_reset();
        m_kbsr_rdy = 0; m_kbsr_ie = 0; m_kbdr = 8'h00;
        m_dsr_rdy = 1;  m_dsr_ie = 0;  m_run = 1; m_dsp_char = 8'h00;
    endtask

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (a < 16'hFE00) return m_ram.exists(a) ? m_ram[a] : 16'h0000;
        case (a)
            16'hFE00: return {m_kbsr_rdy, m_kbsr_ie, 14'b0};
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return {m_dsr_rdy, m_dsr_ie, 14'b0};
            16'hFE06: return {8'h00, m_dsp_char};
            16'hFFFE: return {m_run, 15'b0};
            default:  return 16'h0000;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ddr;
    } acc_t;

    acc_t        exp_acc [$];
    logic [15:0] exp_bus [$];
    int          pulses   = 0;
    int          stray_we = 0;

    // Monitor: checks each completed access and each gated MDR value against the queues.
    initial begin : monitor
        int   run_len;
        int   cyc;
        int   strobe_due;
        acc_t a;
        run_len = 0; cyc = 0; strobe_due = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                run_len = 0;
            end else begin
                if (ram_we && !rdy) stray_we++;
                if (dsp_strobe) begin
                    pulses++;
                    chk("dsp_strobe_cycle", cyc, strobe_due);
                end
                if (rdy) begin
                    if (exp_acc.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rdy: got rdy=1 expected no access pending");
                    end else begin
                        a = exp_acc.pop_front();
                        chk("latency", run_len + 1, LAT);
                        chk("ram_we", ram_we, a.we);
                        if (a.we) begin
                            chk("ram_addr", ram_addr, a.addr);
                            chk("ram_wdata", ram_wdata, a.data);
                        end
                        if (a.ddr) strobe_due = cyc + 1;
                    end
                    run_len = 0;
                end else if (mio_en) begin
                    run_len++;
                end else begin
                    run_len = 0;
                end
                if (gate_mdr) begin
                    if (exp_bus.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_gate: got bus=%h expected no read pending", bus);
                    end else begin
                        chk("bus_read", bus, exp_bus.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_irqs();
        chk("kbd_irq", kbd_irq, m_kbsr_rdy & m_kbsr_ie);
        chk("dsp_irq", dsp_irq, m_dsr_rdy & m_dsr_ie);
        chk("run", run, m_run);
    endtask

    // One full CPU access; optional keyboard strobe and display ack land on the expected rdy cycle.
    task automatic acc(input logic [15:0] a, input logic [15:0] d, input logic wr,
                       input logic kstb, input logic [7:0] kch, input logic ack);
        acc_t        e;
        logic [15:0] rv;
        logic        got;
        int          p0;
        drv_en = 1; drv = a; ld_mar = 1; step(); ld_mar = 0;
        if (wr) begin
            drv = d; ld_mdr = 1; step(); ld_mdr = 0;
        end
        drv_en = 0;
        e.we = wr && (a < 16'hFE00); e.addr = a; e.data = d; e.ddr = wr && (a == 16'hFE06);
        exp_acc.push_back(e);
        p0 = pulses;
        rw = wr; mio_en = 1; ld_mdr = !wr; got = 0;
        for (int i = 0; i < LAT + 6 && !got; i++) begin
            if (i == LAT - 1) begin
                kbd_strobe = kstb; kbd_char = kch; dsp_ack = ack;
            end
            @(negedge clk);
            got = rdy;
            step();
            kbd_strobe = 0; dsp_ack = 0;
        end
        mio_en = 0; ld_mdr = 0; rw = 0;
        if (!got) begin
            total++; bad++;
            $display("FAIL rdy_timeout: got no rdy expected rdy after %0d cycles", LAT);
            exp_acc.delete();
        end
        // Model update: read value first, then ack, read side effect, write, keyboard strobe.
        rv = mread(a);
        if (ack) m_dsr_rdy = 1;
        if (!wr && a == 16'hFE02) m_kbsr_rdy = 0;
        if (wr) begin
            if (a < 16'hFE00) begin
                m_ram[a] = d; written.push_back(a);
            end else begin
                case (a)
                    16'hFE00: m_kbsr_ie = d[14];
                    16'hFE04: m_dsr_ie = d[14];
                    16'hFE06: begin m_dsp_char = d[7:0]; m_dsr_rdy = 0; end
                    16'hFFFE: m_run = d[15];
                    default: ;
                endcase
            end
        end
        if (kstb) begin
            m_kbdr = kch; m_kbsr_rdy = 1;
        end
        if (!wr) begin
            exp_bus.push_back(rv);
            gate_mdr = 1; step(); gate_mdr = 0;
        end
        if (wr && a == 16'hFE06) begin
            chk("dsp_char", dsp_char, m_dsp_char);
            step(); step();
            chk("dsp_pulses", pulses - p0, 1);
        end
        check_irqs();
    endtask

    task automatic kbd(input logic [7:0] c);
        kbd_strobe = 1; kbd_char = c; step(); kbd_strobe = 0;
        m_kbdr = c; m_kbsr_rdy = 1;
    endtask

    task automatic ack_dsp();
        dsp_ack = 1; step(); dsp_ack = 0;
        m_dsr_rdy = 1;
    endtask

    task automatic abort_run(input int n);
        rw = 1; mio_en = 1;
        for (int i = 0; i < n; i++) step();
        mio_en = 0; rw = 0;
        step();
    endtask

    localparam logic [15:0] DEV_RD [6] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE10};
    localparam logic [15:0] DEV_WR [4] = '{16'hFE00, 16'hFE04, 16'hFE06, 16'hFFFE};

    initial begin : timeout
        #1000000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] addr;
        int          op;
        rst = 0; drv = 0; drv_en = 0; ld_mar = 0; ld_mdr = 0; gate_mdr = 0; mio_en = 0; rw = 0;
        kbd_strobe = 0; kbd_char = 0; dsp_ack = 0;
        model_reset();
        #1 rst = 1;
        #20;
        chk("rst_rdy", rdy, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_dsp_strobe", dsp_strobe, 0);
        chk("rst_dsp_char", dsp_char, 8'h00);
        check_irqs();
        step(); rst = 0;

        // RAM write then read.
        acc(16'h3000, 16'hBEEF, 1, 0, 8'h00, 0);
        acc(16'h3000, 16'h0000, 0, 0, 8'h00, 0);

        // Abort after 2 cycles, then a full restart.
        abort_run(2);
        acc(16'h3001, 16'h1234, 1, 0, 8'h00, 0);
        acc(16'h3001, 16'h0000, 0, 0, 8'h00, 0);

        // Keyboard with interrupt enable.
        acc(16'hFE00, 16'h4000, 1, 0, 8'h00, 0);
        kbd(8'h41);
        check_irqs();
        acc(16'hFE00, 16'h0000, 0, 0, 8'h00, 0);
        acc(16'hFE02, 16'h0000, 0, 0, 8'h00, 0);
        acc(16'hFE00, 16'h0000, 0, 0, 8'h00, 0);

        // Display write and ack.
        acc(16'hFE06, 16'h0048, 1, 0, 8'h00, 0);
        acc(16'hFE04, 16'h0000, 0, 0, 8'h00, 0);
        ack_dsp();
        acc(16'hFE04, 16'h0000, 0, 0, 8'h00, 0);

        // Simultaneous events.
        kbd(8'h41);
        acc(16'hFE02, 16'h0000, 0, 1, 8'h42, 0);
        acc(16'hFE00, 16'h0000, 0, 0, 8'h00, 0);
        acc(16'hFE02, 16'h0000, 0, 0, 8'h00, 0);
        acc(16'hFE06, 16'h0055, 1, 0, 8'h00, 1);
        acc(16'hFE04, 16'h0000, 0, 0, 8'h00, 0);

        // MCR write stops the clock without touching RAM.
        acc(16'hFE04, 16'h4000, 1, 0, 8'h00, 0);
        acc(16'hFFFE, 16'h0000, 1, 0, 8'h00, 0);
        acc(16'hFFFE, 16'h0000, 0, 0, 8'h00, 0);

        // Reset mid-write: nothing commits, everything returns to reset values.
        drv_en = 1; drv = 16'h3000; ld_mar = 1; step(); ld_mar = 0;
        drv = 16'h7777; ld_mdr = 1; step(); ld_mdr = 0; drv_en = 0;
        rw = 1; mio_en = 1; step(); step();
        #2 rst = 1;
        #1;
        chk("midrst_rdy", rdy, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", ram_addr, 16'h0000);
        chk("midrst_ram_wdata", ram_wdata, 16'h0000);
        chk("midrst_dsp_char", dsp_char, 8'h00);
        model_reset();
        check_irqs();
        mio_en = 0; rw = 0;
        step(); rst = 0;
        acc(16'h3000, 16'h0000, 0, 0, 8'h00, 0);
        acc(16'hFE04, 16'h0000, 0, 0, 8'h00, 0);

        // Random transactions.
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1, 2: begin
                    addr = 16'($urandom_range(0, 16'hFDFF));
                    acc(addr, 16'($urandom), 1, 0, 8'h00, ($urandom_range(0, 7) == 0));
                end
                3: begin
                    if (written.size() > 0)
                        addr = written[$urandom_range(0, written.size() - 1)];
                    else
                        addr = 16'h3000;
                    acc(addr, 16'h0000, 0, ($urandom_range(0, 5) == 0), 8'($urandom), 0);
                end
                4: acc(DEV_RD[$urandom_range(0, 5)], 16'h0000, 0,
                       ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
                5: acc(DEV_WR[$urandom_range(0, 3)], 16'($urandom), 1,
                       0, 8'h00, ($urandom_range(0, 3) == 0));
                6: begin kbd(8'($urandom)); check_irqs(); end
                default: begin
                    if ($urandom_range(0, 1) == 1) ack_dsp();
                    else abort_run($urandom_range(1, LAT - 1));
                    check_irqs();
                end
            endcase
        end

        step(); step();
        chk("stray_ram_we", stray_we, 0);
        chk("acc_queue_empty", exp_acc.size(), 0);
        chk("bus_queue_empty", exp_bus.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory and memory-mapped I/O controller for the LC-3 Patt CPU. It owns MAR and MDR, drives the shared 16-bit bus when MDR is gated, and sequences each memory access over a fixed number of cycles before asserting ready. It also decodes the device page into keyboard, display and machine-control registers, and raises their interrupt requests toward the interrupt controller.

## Interface
- MEM_LATENCY, 4: cycles of continuous `mio_en` per access, including the ready cycle; legal range ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- bus  inout  16  shared datapath bus; driven only when `gate_mdr`=1, otherwise high-Z.
- ld_mar, ld_mdr, gate_mdr, mio_en, rw  in  1 each  CPU control; `rw`=1 means write.
- rdy  out  1  access complete this cycle.
- ram_addr  out  16  RAM address; equals MAR at all times.
- ram_wdata  out  16  RAM write data; equals MDR at all times.
- ram_we  out  1  RAM write strobe, sampled by RAM on `clk`.
- ram_rdata  in  16  RAM read data, combinational from `ram_addr`.
- kbd_strobe  in  1  one-cycle pulse: new keyboard character.
- kbd_char  in  8  keyboard character, valid with `kbd_strobe`.
- dsp_strobe  out  1  one-cycle pulse: `dsp_char` is valid.
- dsp_char  out  8  display character.
- dsp_ack  in  1  display has consumed the character.
- kbd_irq, dsp_irq  out  1 each  interrupt requests.
- run  out  1  MCR[15], the machine clock enable.

## Operation
- MAR loads `bus` when `ld_mar`=1.
- MDR load source:
  - `ld_mdr`=1 and `mio_en`=1: MDR loads the read mux.
  - `ld_mdr`=1 and `mio_en`=0: MDR loads `bus`.
- Read mux:
  - Addresses below xFE00: `ram_rdata`.
  - xFE00 KBSR, xFE02 KBDR ({8'b0, char}), xFE04 DSR, xFE06 DDR, xFFFE MCR.
  - Any other address at or above xFE00 reads x0000.
- Access sequencer:
  - A 2-bit-or-wider counter `cnt` counts consecutive cycles with `mio_en`=1.
  - `rdy` = `mio_en` & (`cnt` == MEM_LATENCY-1).
  - On `rdy`, `cnt` clears to 0. If `mio_en` is still high, the next access starts on the following cycle.
  - `mio_en`=0 clears `cnt`: the access is aborted with no side effects.
- All side effects happen only in the `rdy` cycle:
  - Write below xFE00: `ram_we`=1.
  - Write to device space: updates the target register; `ram_we` stays 0.
  - Read of KBDR: clears KBSR[15].
- Register bits:
  - KBSR: [15] ready (read-only to the CPU), [14] IE (writable); other bits read 0.
  - DSR: [15] ready (read-only), [14] IE (writable).
  - MCR: only [15] is implemented.
- Keyboard: `kbd_strobe` loads KBDR with `kbd_char` and sets KBSR[15]. If KBSR[15] is already set, the character is overwritten.
- Display: a write to DDR does three things:
  - loads `dsp_char` from MDR[7:0];
  - pulses `dsp_strobe` on the next cycle;
  - clears DSR[15].
  
  `dsp_ack` sets DSR[15]. A DDR write is accepted even when DSR[15]=0.
- Interrupts: `kbd_irq` = KBSR[15]&KBSR[14]; `dsp_irq` = DSR[15]&DSR[14]. Both are registered-state combinational.
- Simultaneous events:
  - `kbd_strobe` in the same cycle as a completing KBDR read: strobe wins (KBSR[15]=1, new char).
  - `dsp_ack` in the same cycle as a completing DDR write: the write wins (DSR[15]=0).
  - `ld_mdr` together with `gate_mdr`: the bus carries the old MDR.
- MAR and MDR must stay stable while `mio_en`=1. Changing them mid-access is a microcode error; the controller takes no protective action.

## Timing
- Reset values:
  - MAR=0, MDR=0, `cnt`=0.
  - `rdy`=0, `ram_we`=0, `dsp_strobe`=0, `dsp_char`=0.
  - KBSR=0, KBDR=0, DSR=x8000, MCR=x8000, so `run`=1.
  - `kbd_irq`=0, `dsp_irq`=0.
  - `bus` high-Z.
- Reset asserted mid-access aborts immediately: no write commits and no device side effect occurs.
- `mio_en` first high in cycle t: `rdy`=1 in cycle t+MEM_LATENCY-1. With MEM_LATENCY=1, `rdy` is high in cycle t.
- Read with `ld_mdr` held throughout: MDR holds read data from the edge that ends the `rdy` cycle.
- `bus` drive follows `gate_mdr` combinationally within the same cycle.
- `dsp_strobe` is high exactly one cycle, starting the cycle after the DDR-write `rdy`.

## Test plan
- Write then read RAM, MEM_LATENCY=4:
  - MAR=x3000, MDR=xBEEF, `rw`=1, `mio_en` held → `ram_we`=1 only in the 4th cycle.
  - Then read with `ld_mdr` → MDR=xBEEF, and `bus`=xBEEF under `gate_mdr`.
- Abort: `mio_en` high for 2 cycles then low → `rdy` and `ram_we` never assert; a restart needs the full 4 cycles.
- Keyboard:
  - `kbd_strobe` with x41 and IE set via a write of x4000 to xFE00 → KBSR reads xC000 and `kbd_irq`=1.
  - KBDR read returns x0041, then KBSR=x4000 and `kbd_irq`=0.
- Display:
  - Write x0048 to xFE06 → `dsp_char`=x48, one `dsp_strobe` pulse, DSR reads x0000.
  - `dsp_ack` → DSR reads x8000.
- Simultaneous events:
  - `kbd_strobe` x42 on the KBDR-read `rdy` cycle → KBSR[15] stays 1, KBDR=x0042.
  - `dsp_ack` on the DDR-write `rdy` cycle → DSR[15]=0.
- Reset and MCR:
  - Write x0000 to xFFFE → `run`=0, RAM is not written.
  - Assert `rst` mid-access → all outputs return to reset values and `run`=1.
